// File: rtl/pc_pkg.sv
// Shared types and default constants for the next-PC controller.
package pc_pkg;

    localparam int WIDTH = 16;

    typedef logic [WIDTH-1:0] addr_t;

    localparam addr_t RESET_VEC_DEF = 16'h0000;
    localparam addr_t IRQ_VEC_DEF   = 16'h0004;
    localparam addr_t INC_DEF       = 16'h0001;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        IACK
    } state_t;

    // A redirect request: is_eret remembers that taking it must re-enable interrupts.
    typedef struct packed {
        logic  valid;
        logic  is_eret;
        addr_t target;
    } redirect_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of the fetch, redirect and interrupt signals around the next-PC controller.
interface pc_sequencer_if;

    pc_pkg::addr_t pc_count;
    pc_pkg::addr_t pc_next;
    logic          imem_req;
    logic          imem_ready;
    logic          stall;
    logic          branch_taken;
    pc_pkg::addr_t branch_target;
    logic          jump;
    pc_pkg::addr_t jump_target;
    logic          eret;
    logic          irq;
    logic          irq_ack;
    logic          irq_en;
    pc_pkg::addr_t epc;

    // Pipeline / PC-register side that drives the controller.
    modport master (
        output pc_count, imem_ready, stall, branch_taken, branch_target,
               jump, jump_target, eret, irq,
        input  pc_next, imem_req, irq_ack, irq_en, epc
    );

    // The controller itself.
    modport slave (
        input  pc_count, imem_ready, stall, branch_taken, branch_target,
               jump, jump_target, eret, irq,
        output pc_next, imem_req, irq_ack, irq_en, epc
    );

endinterface

// File: rtl/pc_sequencer_redirect_buf.sv
// One-entry pending-redirect buffer: holds a redirect that arrived while the
// PC could not advance, and picks between a fresh request and the held one.
module redirect_buf
    import pc_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      flush_i,
    input  logic      capture_i,
    input  redirect_t req_i,
    output redirect_t pend_o,
    output redirect_t sel_o
);

    redirect_t pend_q;
    redirect_t pend_d;

    // Newer requests overwrite the held one; an advancing cycle consumes it.
    always_comb begin
        pend_d = pend_q;
        if (flush_i) begin
            pend_d = '0;
        end else if (capture_i && req_i.valid) begin
            pend_d = req_i;
        end
    end

    // Buffer register, emptied by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;
    assign sel_o  = req_i.valid ? req_i : pend_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: boot sequencing, redirect priority, pending redirects,
// interrupt entry and exception return for the 16-bit core.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter addr_t RESET_VEC = RESET_VEC_DEF,
    parameter addr_t IRQ_VEC   = IRQ_VEC_DEF,
    parameter addr_t INC       = INC_DEF
)
(
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    state_t    state_q, state_d;
    logic      irq_en_q, irq_en_d;
    addr_t     epc_q, epc_d;

    redirect_t req;
    redirect_t pend;
    redirect_t sel;
    logic      advance;
    logic      flush;
    logic      capture;
    addr_t     pc_next_c;
    logic      imem_req_c;
    logic      irq_ack_c;

    assign advance = bus.imem_ready & ~bus.stall;

    // Resolve this cycle's redirect: eret beats jump beats branch.
    always_comb begin
        req.valid   = bus.eret | bus.jump | bus.branch_taken;
        req.is_eret = bus.eret;
        if (bus.eret) begin
            req.target = epc_q;
        end else if (bus.jump) begin
            req.target = bus.jump_target;
        end else begin
            req.target = bus.branch_target;
        end
    end

    redirect_buf u_redirect_buf (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (flush),
        .capture_i (capture),
        .req_i     (req),
        .pend_o    (pend),
        .sel_o     (sel)
    );

    // Next-state and output decode; reset forces the fetch outputs to the boot values.
    always_comb begin
        state_d    = state_q;
        irq_en_d   = irq_en_q;
        epc_d      = epc_q;
        pc_next_c  = bus.pc_count;
        imem_req_c = 1'b0;
        irq_ack_c  = 1'b0;
        flush      = 1'b0;
        capture    = 1'b0;
        case (state_q)
            BOOT: begin
                pc_next_c = RESET_VEC;
                state_d   = RUN;
                irq_en_d  = 1'b1;
            end
            RUN: begin
                imem_req_c = 1'b1;
                if (advance) begin
                    flush = 1'b1;
                    if (bus.irq && irq_en_q) begin
                        pc_next_c = IRQ_VEC;
                        if (pend.valid) begin
                            epc_d = pend.target;
                        end else if (req.valid) begin
                            epc_d = req.target;
                        end else begin
                            epc_d = bus.pc_count + INC;
                        end
                        irq_en_d = 1'b0;
                        state_d  = IACK;
                    end else if (sel.valid) begin
                        pc_next_c = sel.target;
                        if (sel.is_eret) begin
                            irq_en_d = 1'b1;
                        end
                    end else begin
                        pc_next_c = bus.pc_count + INC;
                    end
                end else begin
                    capture = 1'b1;
                end
            end
            IACK: begin
                irq_ack_c = 1'b1;
                capture   = 1'b1;
                state_d   = RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        if (reset) begin
            pc_next_c  = RESET_VEC;
            imem_req_c = 1'b0;
            irq_ack_c  = 1'b0;
        end
    end

    // State, interrupt-enable and return-address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BOOT;
            irq_en_q <= 1'b0;
            epc_q    <= '0;
        end else begin
            state_q  <= state_d;
            irq_en_q <= irq_en_d;
            epc_q    <= epc_d;
        end
    end

    assign bus.pc_next  = pc_next_c;
    assign bus.imem_req = imem_req_c;
    assign bus.irq_ack  = irq_ack_c;
    assign bus.irq_en   = irq_en_q;
    assign bus.epc      = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, checked
// against a behavioural model through an expected-value queue.
module tb_pc_sequencer;

    localparam logic [15:0] RV  = 16'h0000;
    localparam logic [15:0] IV  = 16'h0004;

    localparam int MODE_BOOT = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_ACK  = 2;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        stall;
        logic        branch;
        logic [15:0] branchTarget;
        logic        jump;
        logic [15:0] jumpTarget;
        logic        eret;
        logic        irq;
    } stim_t;

    typedef struct {
        logic [15:0] pcCount;
        logic [15:0] pcNext;
        logic        imemReq;
        logic        irqAck;
        logic        irqEn;
        logic [15:0] epc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] pcReg;
    int          checks;
    int          errors;
    exp_t        expQ[$];

    int          mMode;
    logic [15:0] mPc;
    logic        mIrqEn;
    logic [15:0] mEpc;
    logic        mPendValid;
    logic [15:0] mPendTarget;
    logic        mPendEret;

    pc_sequencer_if ifc();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The external PC register, loading pc_next every edge.
    always @(posedge clk) begin
        pcReg <= ifc.pc_next;
    end
    assign ifc.pc_count = pcReg;

    function automatic stim_t idle(input logic rdy);
        stim_t s;
        s.rst          = 1'b0;
        s.ready        = rdy;
        s.stall        = 1'b0;
        s.branch       = 1'b0;
        s.branchTarget = 16'h0000;
        s.jump         = 1'b0;
        s.jumpTarget   = 16'h0000;
        s.eret         = 1'b0;
        s.irq          = 1'b0;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the response, queue it, then step a clock.
    task automatic applyStimulus(input stim_t s);
        exp_t        e;
        logic        reqV;
        logic        reqE;
        logic [15:0] reqT;
        logic [15:0] nxt;
        logic        adv;

        reset             = s.rst;
        ifc.imem_ready    = s.ready;
        ifc.stall         = s.stall;
        ifc.branch_taken  = s.branch;
        ifc.branch_target = s.branchTarget;
        ifc.jump          = s.jump;
        ifc.jump_target   = s.jumpTarget;
        ifc.eret          = s.eret;
        ifc.irq           = s.irq;

        e.pcCount = mPc;
        e.irqEn   = mIrqEn;
        e.epc     = mEpc;
        e.imemReq = 1'b0;
        e.irqAck  = 1'b0;

        reqV = s.eret | s.jump | s.branch;
        reqE = s.eret;
        reqT = s.eret ? mEpc : (s.jump ? s.jumpTarget : s.branchTarget);
        adv  = s.ready & ~s.stall;
        nxt  = mPc;

        if (s.rst) begin
            nxt        = RV;
            mMode      = MODE_BOOT;
            mIrqEn     = 1'b0;
            mEpc       = 16'h0000;
            mPendValid = 1'b0;
        end else if (mMode == MODE_BOOT) begin
            nxt    = RV;
            mMode  = MODE_RUN;
            mIrqEn = 1'b1;
        end else if (mMode == MODE_RUN) begin
            e.imemReq = 1'b1;
            if (adv) begin
                if (s.irq && mIrqEn) begin
                    nxt    = IV;
                    mEpc   = mPendValid ? mPendTarget : (reqV ? reqT : mPc + 16'h0001);
                    mIrqEn = 1'b0;
                    mMode  = MODE_ACK;
                end else if (reqV) begin
                    nxt = reqT;
                    if (reqE) mIrqEn = 1'b1;
                end else if (mPendValid) begin
                    nxt = mPendTarget;
                    if (mPendEret) mIrqEn = 1'b1;
                end else begin
                    nxt = mPc + 16'h0001;
                end
                mPendValid = 1'b0;
            end else if (reqV) begin
                mPendValid  = 1'b1;
                mPendTarget = reqT;
                mPendEret   = reqE;
            end
        end else begin
            e.irqAck = 1'b1;
            mMode    = MODE_RUN;
            if (reqV) begin
                mPendValid  = 1'b1;
                mPendTarget = reqT;
                mPendEret   = reqE;
            end
        end

        e.pcNext = nxt;
        mPc      = nxt;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: mid-cycle, pop the prediction for this cycle and compare every output.
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("pc_count", ifc.pc_count, e.pcCount);
            checkOutput("pc_next", ifc.pc_next, e.pcNext);
            checkOutput("imem_req", {15'h0, ifc.imem_req}, {15'h0, e.imemReq});
            checkOutput("irq_ack", {15'h0, ifc.irq_ack}, {15'h0, e.irqAck});
            checkOutput("irq_en", {15'h0, ifc.irq_en}, {15'h0, e.irqEn});
            checkOutput("epc", ifc.epc, e.epc);
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        stim_t s;
        logic  irqLvl;

        checks = 0;
        errors = 0;
        reset             = 1'b1;
        ifc.imem_ready    = 1'b0;
        ifc.stall         = 1'b0;
        ifc.branch_taken  = 1'b0;
        ifc.branch_target = 16'h0000;
        ifc.jump          = 1'b0;
        ifc.jump_target   = 16'h0000;
        ifc.eret          = 1'b0;
        ifc.irq           = 1'b0;
        @(posedge clk);
        #1;
        mMode       = MODE_BOOT;
        mPc         = RV;
        mIrqEn      = 1'b0;
        mEpc        = 16'h0000;
        mPendValid  = 1'b0;
        mPendTarget = 16'h0000;
        mPendEret   = 1'b0;

        s = idle(1'b1); s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
        repeat (6) applyStimulus(idle(1'b1));

        s = idle(1'b0); s.branch = 1'b1; s.branchTarget = 16'h0040;
        applyStimulus(s);
        applyStimulus(idle(1'b0));
        applyStimulus(idle(1'b0));
        applyStimulus(idle(1'b1));
        applyStimulus(idle(1'b1));

        s = idle(1'b1); s.jump = 1'b1; s.jumpTarget = 16'h0080; s.branch = 1'b1; s.branchTarget = 16'h0090;
        applyStimulus(s);
        s = idle(1'b1); s.stall = 1'b1; s.branch = 1'b1; s.branchTarget = 16'h0020;
        applyStimulus(s);
        s = idle(1'b1); s.stall = 1'b1; s.jump = 1'b1; s.jumpTarget = 16'h0030;
        applyStimulus(s);
        applyStimulus(idle(1'b1));
        applyStimulus(idle(1'b1));

        s = idle(1'b1); s.jump = 1'b1; s.jumpTarget = 16'h0010;
        applyStimulus(s);
        s = idle(1'b1); s.irq = 1'b1;
        repeat (4) applyStimulus(s);
        s = idle(1'b1); s.eret = 1'b1;
        applyStimulus(s);
        applyStimulus(idle(1'b1));

        s = idle(1'b1); s.jump = 1'b1; s.jumpTarget = 16'hFFFF;
        applyStimulus(s);
        applyStimulus(idle(1'b1));
        applyStimulus(idle(1'b1));

        s = idle(1'b1); s.stall = 1'b1; s.branch = 1'b1; s.branchTarget = 16'h0055;
        applyStimulus(s);
        s = idle(1'b1); s.stall = 1'b1; s.rst = 1'b1;
        applyStimulus(s);
        repeat (4) applyStimulus(idle(1'b1));

        irqLvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) irqLvl = ~irqLvl;
            s.rst          = ($urandom_range(0, 199) == 0);
            s.ready        = ($urandom_range(0, 3) != 0);
            s.stall        = ($urandom_range(0, 4) == 0);
            s.branch       = ($urandom_range(0, 9) == 0);
            s.branchTarget = 16'($urandom);
            s.jump         = ($urandom_range(0, 19) == 0);
            s.jumpTarget   = 16'($urandom);
            s.eret         = ($urandom_range(0, 24) == 0);
            s.irq          = irqLvl;
            applyStimulus(s);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d expected=0 predictions left unchecked", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
